// File: rtl/mem_stage_ws.sv
// mem_stage_ws: MEM stage of the 5-stage MIPS pipeline.
// It does data-memory access with a fixed number of wait states.
// It handles byte/half/word loads and stores, with sign or zero extension on loads.
// It flags misaligned accesses and holds a registered MEM/WB pipeline register.
// A combinational stall holds the upstream stages while an access is in flight.

module mem_stage_ws #(
    parameter int DATA_W      = 32,
    parameter int REG_W       = 5,
    parameter int DEPTH_WORDS = 1024,
    parameter int MEM_LAT     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              load_unsigned,
    input  logic [REG_W-1:0]  rd_in,
    input  logic [REG_W-1:0]  dest_in,
    input  logic [DATA_W-1:0] addr_or_res_in,
    input  logic [DATA_W-1:0] store_data,
    output logic              stall,
    output logic              wb_valid,
    output logic              reg_write,
    output logic              mem_to_reg,
    output logic [REG_W-1:0]  rd,
    output logic [REG_W-1:0]  dest,
    output logic [DATA_W-1:0] mem_out,
    output logic [DATA_W-1:0] addr_or_res,
    output logic              misaligned
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int NB = DATA_W / 8;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    localparam logic [2:0] LAT_INIT = 3'((MEM_LAT > 0) ? (MEM_LAT - 1) : 0);

    // Storage: one word per entry, not reset (contents are undefined until written).
    logic [DATA_W-1:0] mem_array [DEPTH_WORDS];

    logic              state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;

    logic              wb_valid_q, wb_valid_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [REG_W-1:0]  dest_q, dest_d;
    logic [DATA_W-1:0] mem_out_q, mem_out_d;
    logic [DATA_W-1:0] addr_or_res_q, addr_or_res_d;
    logic              misaligned_q, misaligned_d;

    logic              mem_op;
    logic              is_store;
    logic              is_load;
    logic [1:0]        lane;
    logic              misalign;
    logic [AW-1:0]     word_idx;
    logic [DATA_W-1:0] rd_word;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_ext;
    logic [DATA_W-1:0] wr_data;
    logic [NB-1:0]     wr_be;
    logic              access_now;
    logic              mem_we;
    logic              stall_raw;
    logic              capture_bubble;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^addr_or_res_in[DATA_W-1:AW+2];

    assign lane     = addr_or_res_in[1:0];
    assign word_idx = addr_or_res_in[AW+1:2];
    assign rd_word  = mem_array[word_idx];

    // Decode the operation type and detect misaligned half/word accesses.
    always_comb begin
        mem_op   = in_valid & (mem_read | mem_write);
        is_store = mem_write;
        is_load  = mem_read & ~mem_write;
        misalign = 1'b0;
        case (size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = lane[0];
            default: misalign = (lane != 2'b00);
        endcase
    end

    // Select the addressed byte/half lane from the read word and extend it.
    always_comb begin
        ld_byte = rd_word[{lane, 3'b000} +: 8];
        ld_half = rd_word[{lane[1], 4'b0000} +: 16];
        ld_ext  = rd_word;
        case (size)
            2'b00: ld_ext = load_unsigned ? {{(DATA_W-8){1'b0}}, ld_byte}
                                          : {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            2'b01: ld_ext = load_unsigned ? {{(DATA_W-16){1'b0}}, ld_half}
                                          : {{(DATA_W-16){ld_half[15]}}, ld_half};
            default: ld_ext = rd_word;
        endcase
    end

    // Build little-endian byte enables and replicate store data across lanes.
    always_comb begin
        wr_be   = '1;
        wr_data = store_data;
        case (size)
            2'b00: begin
                wr_be   = NB'(1) << lane;
                wr_data = {NB{store_data[7:0]}};
            end
            2'b01: begin
                wr_be   = NB'(3) << {lane[1], 1'b0};
                wr_data = {(NB/2){store_data[15:0]}};
            end
            default: begin
                wr_be   = '1;
                wr_data = store_data;
            end
        endcase
    end

    // Wait-state FSM: an access completes on the cycle the countdown reaches zero.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        stall_raw      = 1'b0;
        capture_bubble = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op && (MEM_LAT > 0)) begin
                    stall_raw      = 1'b1;
                    capture_bubble = 1'b1;
                    cnt_d          = LAT_INIT;
                    state_d        = ST_WAIT;
                end
            end
            default: begin
                if (cnt_q != 3'd0) begin
                    stall_raw      = 1'b1;
                    capture_bubble = 1'b1;
                    cnt_d          = cnt_q - 3'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    assign access_now = mem_op & ((MEM_LAT == 0) | ((state_q == ST_WAIT) & (cnt_q == 3'd0)));
    assign mem_we     = access_now & is_store & ~misalign;
    assign stall      = stall_raw & ~rst;

    // Next MEM/WB contents: a bubble while waiting, otherwise the completed slot.
    always_comb begin
        wb_valid_d    = in_valid;
        reg_write_d   = in_valid & reg_write_in & ~(mem_op & misalign);
        mem_to_reg_d  = in_valid & mem_to_reg_in;
        rd_d          = rd_in;
        dest_d        = dest_in;
        addr_or_res_d = addr_or_res_in;
        mem_out_d     = (mem_op && is_load && !misalign) ? ld_ext : '0;
        misaligned_d  = mem_op & misalign;
        if (capture_bubble) begin
            wb_valid_d    = 1'b0;
            reg_write_d   = 1'b0;
            mem_to_reg_d  = 1'b0;
            rd_d          = '0;
            dest_d        = '0;
            addr_or_res_d = '0;
            mem_out_d     = '0;
            misaligned_d  = 1'b0;
        end
    end

    // Byte-enabled write on the completing edge of an aligned store.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    mem_array[word_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // FSM state, countdown and MEM/WB register; reset drops any pending access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 3'd0;
            wb_valid_q    <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            rd_q          <= '0;
            dest_q        <= '0;
            mem_out_q     <= '0;
            addr_or_res_q <= '0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wb_valid_q    <= wb_valid_d;
            reg_write_q   <= reg_write_d;
            mem_to_reg_q  <= mem_to_reg_d;
            rd_q          <= rd_d;
            dest_q        <= dest_d;
            mem_out_q     <= mem_out_d;
            addr_or_res_q <= addr_or_res_d;
            misaligned_q  <= misaligned_d;
        end
    end

    assign wb_valid    = wb_valid_q;
    assign reg_write   = reg_write_q;
    assign mem_to_reg  = mem_to_reg_q;
    assign rd          = rd_q;
    assign dest        = dest_q;
    assign mem_out     = mem_out_q;
    assign addr_or_res = addr_or_res_q;
    assign misaligned  = misaligned_q;

endmodule
